// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal shift register with frame counter and masked pattern match
module univ_shift_reg #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   PATTERN = '0,
  parameter logic [WIDTH-1:0]   MASK    = '1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             si,
  input  logic             sil,
  input  logic [WIDTH-1:0] pi,
  output logic [WIDTH-1:0] po,
  output logic             so,
  output logic             sol,
  output logic             frame_valid,
  output logic             match
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] q, q_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic             fv_next;
  logic             shifting;

  // Next register contents, frame count and frame pulse from the current command.
  always_comb begin
    q_next   = q;
    cnt_next = cnt;
    fv_next  = 1'b0;
    shifting = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_next = q;
        end
        MODE_RIGHT: begin
          q_next   = {si, q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_LEFT: begin
          q_next   = {q[WIDTH-2:0], sil};
          shifting = 1'b1;
        end
        MODE_LOAD: begin
          // A load restarts framing, even when it lands on the final shift slot.
          q_next   = pi;
          cnt_next = '0;
        end
        default: begin
          q_next = q;
        end
      endcase
      // Both shift directions advance the same frame count.
      if (shifting) begin
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          fv_next  = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
    end
  end

  // State registers; reset clears everything, including any partial frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q           <= '0;
      cnt         <= '0;
      frame_valid <= 1'b0;
    end else begin
      q           <= q_next;
      cnt         <= cnt_next;
      frame_valid <= fv_next;
    end
  end

  assign po    = q;
  assign so    = q[0];
  assign sol   = q[WIDTH-1];
  // Match depends on the register only, never on an input port.
  assign match = ((q ^ PATTERN) & MASK) == '0;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  logic       clk;
  logic       resetn;
  logic       en;
  logic [1:0] mode;
  logic       si;
  logic       sil;
  logic [3:0] pi;
  logic [7:0] pi8;

  logic [3:0] po4, pod;
  logic       so4, sol4, fv4, match4;
  logic       sod, sold, fvd, matchd;
  logic [7:0] po8;
  logic       so8, sol8, fv8, match8;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [3:0] po;
    logic       so;
    logic       sol;
    logic       fv;
    logic       m;
    logic       md;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] m_q;
  int         m_cnt;
  logic       m_fv;

  univ_shift_reg #(.WIDTH(4), .PATTERN(4'b1101)) u4 (
    .clk(clk), .resetn(resetn), .en(en), .mode(mode), .si(si), .sil(sil), .pi(pi),
    .po(po4), .so(so4), .sol(sol4), .frame_valid(fv4), .match(match4)
  );

  univ_shift_reg u4d (
    .clk(clk), .resetn(resetn), .en(en), .mode(mode), .si(si), .sil(sil), .pi(pi),
    .po(pod), .so(sod), .sol(sold), .frame_valid(fvd), .match(matchd)
  );

  univ_shift_reg #(.WIDTH(8), .PATTERN(8'hA0), .MASK(8'hF0)) u8 (
    .clk(clk), .resetn(resetn), .en(en), .mode(mode), .si(si), .sil(sil), .pi(pi8),
    .po(po8), .so(so8), .sol(sol8), .frame_valid(fv8), .match(match8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_q   = 4'b0000;
    m_cnt = 0;
    m_fv  = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.po  = m_q;
    e.so  = m_q[0];
    e.sol = m_q[3];
    e.fv  = m_fv;
    e.m   = (m_q == 4'b1101);
    e.md  = (m_q == 4'b0000);
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_po"}, 32'(po4), 32'(e.po));
    chk({tag, "_so"}, 32'(so4), 32'(e.so));
    chk({tag, "_sol"}, 32'(sol4), 32'(e.sol));
    chk({tag, "_fv"}, 32'(fv4), 32'(e.fv));
    chk({tag, "_match"}, 32'(match4), 32'(e.m));
    chk({tag, "_match_dflt"}, 32'(matchd), 32'(e.md));
  endtask

  // One clock of stimulus: predict, push, wait for the edge, pop and compare.
  task automatic drive(input string tag, input logic e, input logic [1:0] md,
                       input logic s, input logic sl, input logic [3:0] p, input logic [7:0] p8);
    logic shifted;
    en = e; mode = md; si = s; sil = sl; pi = p; pi8 = p8;
    shifted = 1'b0;
    m_fv = 1'b0;
    if (e) begin
      case (md)
        2'b01: begin m_q = {s, m_q[3:1]}; shifted = 1'b1; end
        2'b10: begin m_q = {m_q[2:0], sl}; shifted = 1'b1; end
        2'b11: begin m_q = p; m_cnt = 0; end
        default: ;
      endcase
      if (shifted) begin
        if (m_cnt == 3) begin
          m_cnt = 0;
          m_fv  = 1'b1;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    push_exp();
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic sync_reset_cycle();
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    logic [7:0] b0, b1;
    b0 = 8'hA5;
    b1 = 8'h3C;
    resetn = 1'b0; en = 1'b0; mode = 2'b00; si = 1'b0; sil = 1'b0; pi = 4'b0; pi8 = 8'h00;
    model_reset();

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_po", 32'(po4), 32'h0);
    chk("rst_so", 32'(so4), 32'h0);
    chk("rst_sol", 32'(sol4), 32'h0);
    chk("rst_fv", 32'(fv4), 32'h0);
    chk("rst_match_pat", 32'(match4), 32'h0);
    chk("rst_match_dflt", 32'(matchd), 32'h1);
    resetn = 1'b1;
    drive("rel_hold", 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 8'h00);

    // Right shift 1,0,1,1.
    drive("rs1", 1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 8'h00);
    chk("rs1_const", 32'(po4), 32'b1000);
    drive("rs2", 1'b1, 2'b01, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("rs2_const", 32'(po4), 32'b0100);
    drive("rs3", 1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 8'h00);
    chk("rs3_fv_low", 32'(fv4), 32'h0);
    drive("rs4", 1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 8'h00);
    chk("rs4_const", 32'(po4), 32'b1101);
    chk("rs4_fv_const", 32'(fv4), 32'h1);
    chk("rs4_match_const", 32'(match4), 32'h1);
    drive("rs_after", 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("rs_after_fv_const", 32'(fv4), 32'h0);

    // Load then left shift.
    drive("ld", 1'b1, 2'b11, 1'b0, 1'b0, 4'b0110, 8'h00);
    chk("ld_const", 32'(po4), 32'b0110);
    drive("ls1", 1'b1, 2'b10, 1'b0, 1'b1, 4'h0, 8'h00);
    chk("ls1_const", 32'(po4), 32'b1101);
    chk("ls1_sol_const", 32'(sol4), 32'h1);
    drive("ls2", 1'b1, 2'b10, 1'b0, 1'b0, 4'h0, 8'h00);
    drive("ls3", 1'b1, 2'b10, 1'b0, 1'b0, 4'h0, 8'h00);
    drive("ls4", 1'b1, 2'b10, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("ls4_const", 32'(po4), 32'b1000);
    chk("ls4_fv_const", 32'(fv4), 32'h1);

    // Enable gating mid-frame.
    drive("en_ld", 1'b1, 2'b11, 1'b0, 1'b0, 4'b0000, 8'h00);
    drive("en_s1", 1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 8'h00);
    drive("en_s2", 1'b1, 2'b01, 1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 3; i++) drive("en_off", 1'b0, 2'b01, 1'b1, 1'b1, 4'hF, 8'h00);
    chk("en_off_po_const", 32'(po4), 32'b0100);
    drive("en_s3", 1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 8'h00);
    drive("en_s4", 1'b1, 2'b01, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("en_s4_fv_const", 32'(fv4), 32'h1);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 3; i++) drive("pre_rst", 1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 8'h00);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_po", 32'(po4), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) drive("post_rst", 1'b1, 2'b01, 1'b1, 1'b0, 4'h0, 8'h00);
    chk("post_rst_fv_const", 32'(fv4), 32'h1);

    // Load on the final shift slot pre-empts the pulse.
    drive("pe_ld", 1'b1, 2'b11, 1'b0, 1'b0, 4'b0011, 8'h00);
    for (int i = 0; i < 3; i++) drive("pe_sh", 1'b1, 2'b10, 1'b0, 1'b1, 4'h0, 8'h00);
    drive("pe_ld4", 1'b1, 2'b11, 1'b0, 1'b0, 4'b1001, 8'h00);
    chk("pe_ld4_fv_const", 32'(fv4), 32'h0);
    for (int i = 0; i < 3; i++) drive("pe_fresh", 1'b1, 2'b01, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("pe_fresh3_fv_const", 32'(fv4), 32'h0);
    drive("pe_fresh4", 1'b1, 2'b01, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("pe_fresh4_fv_const", 32'(fv4), 32'h1);

    // WIDTH=8 masked match over two back-to-back frames, LSB first.
    sync_reset_cycle();
    chk("w8_rst_po", 32'(po8), 32'h0);
    for (int i = 0; i < 16; i++) begin
      drive("w8", 1'b1, 2'b01, (i < 8) ? b0[i] : b1[i-8], 1'b0, 4'h0, 8'h00);
      chk($sformatf("w8_fv_%0d", i + 1), 32'(fv8), 32'((i == 7) || (i == 15)));
      if (i == 7) begin
        chk("w8_po_a5", 32'(po8), 32'hA5);
        chk("w8_match_a5", 32'(match8), 32'h1);
      end
      if (i == 15) begin
        chk("w8_po_3c", 32'(po8), 32'h3C);
        chk("w8_match_3c", 32'(match8), 32'h0);
      end
    end
    drive("w8_end", 1'b1, 2'b00, 1'b0, 1'b0, 4'h0, 8'h00);
    chk("w8_end_fv", 32'(fv8), 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register. It is the next generation of the team's fixed 4-bit serial-in/parallel-out chain, generalised to WIDTH bits. It adds hold, right-shift, left-shift and parallel-load modes, a frame counter that flags every WIDTH consecutive shifts, and a maskable pattern detector on the parallel output. It sits at serial-link boundaries for serial-to-parallel and parallel-to-serial conversion, and for framing.

Parameters:
WIDTH, 4, register width in bits; legal values 2..32.
PATTERN, {WIDTH{1'b0}}, compare value for the match output.
MASK, {WIDTH{1'b1}}, compare-enable per bit; 1 = bit participates in the compare.

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
en  input  1  clock enable; 0 freezes all state
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
si  input  1  serial in for shift right; enters MSB
sil  input  1  serial in for shift left; enters LSB
pi  input  WIDTH  parallel load data
po  output  WIDTH  register contents q
so  output  1  q[0]; right-shift serial out
sol  output  1  q[WIDTH-1]; left-shift serial out
frame_valid  output  1  registered 1-cycle pulse after WIDTH shifts complete
match  output  1  combinational: ((q ^ PATTERN) & MASK) == 0

Behaviour:
- One clock domain. Reset is asynchronous and active-low. State is q[WIDTH-1:0], cnt[$clog2(WIDTH+1)-1:0] and frame_valid.
- While resetn=0: q=0, cnt=0, frame_valid=0, regardless of clk or en. po=0, so=0, sol=0. match reflects q=0, so it is 1 with the default parameters.
- Deassertion of resetn takes effect at the next rising edge. No synchroniser inside the block; the parent supplies a synchronised release.
- en=0: q, cnt hold; frame_valid is forced to 0 at the next edge.
- en=1, at each rising edge:
  - mode 00: q and cnt hold; frame_valid <= 0.
  - mode 01: q <= {si, q[WIDTH-1:1]}.
  - mode 10: q <= {q[WIDTH-2:0], sil}.
  - mode 11: q <= pi; cnt <= 0; frame_valid <= 0.
- Frame counter, applies to shift modes 01 and 10:
  - cnt counts shifts since the last reset or load, including mixed-direction shifts.
  - If cnt == WIDTH-1: cnt <= 0 and frame_valid <= 1 (wrap).
  - Otherwise: cnt <= cnt+1 and frame_valid <= 0.
- frame_valid is high for exactly the one cycle following the WIDTH-th shift edge, so po holds the complete frame while frame_valid=1. Back-to-back frames give a pulse every WIDTH shift cycles.
- Latency: po/so/sol update one edge after the command. match follows po combinationally, with zero added latency.
- Load during the final shift slot takes priority: no frame_valid, cnt=0.
- Reset mid-frame discards the partial frame; the next frame_valid needs WIDTH fresh shifts.
- All outputs are driven from flops, except match, which is a combinational function of q only. match has no path from any input port.

Test Plan:
- Reset, WIDTH=4: hold resetn=0 for 2 cycles, then release -> po=0000, so=0, sol=0, frame_valid=0, match=1. Pull resetn low mid-cycle with no clk edge -> po clears immediately.
- Right shift, WIDTH=4, PATTERN=4'b1101: en=1, mode=01, si=1,0,1,1 over 4 edges -> po=1000, 0100, 1010, 1101. so=1 after the 4th edge. frame_valid=1 for exactly that one cycle. match=1 only after the 4th edge.
- Load then left shift: mode=11 with pi=0110 -> po=0110, cnt=0, sol=0. Then mode=10 with sil=1 -> po=1101, sol=1. Three more shifts with sil=0 -> frame_valid pulses after the 4th shift, po=1000.
- Enable/hold: after 2 right shifts, en=0 with mode=01 for 3 cycles -> po unchanged, no pulse. Then en=1 plus 2 more shifts -> frame_valid pulses after the 2nd of these shifts, for 4 shifts total.
- Reset mid-frame and load pre-emption: 3 shifts, then async reset, then 4 shifts -> a single pulse after the last of the 4. In a separate run, 3 shifts then load on the 4th slot -> no pulse, cnt=0.
- WIDTH=8, MASK=8'hF0, PATTERN=8'hA0: 16 continuous right shifts of 0xA5 then 0x3C, LSB first -> frame_valid pulses on cycles 8 and 16. po=A5 at the first pulse, with match=1 via the masked upper nibble. po=3C at the second pulse, with match=0.
